// File: rtl/confreg_pkg.sv
// Shared constants and helpers for the board configuration register block.
package confreg_pkg;

  localparam logic [15:0] OFF_LED        = 16'hF000;
  localparam logic [15:0] OFF_SWITCH     = 16'hF004;
  localparam logic [15:0] OFF_NUM        = 16'hF008;
  localparam logic [15:0] OFF_SCRATCH    = 16'hFFF0;
  localparam logic [15:0] OFF_TIMER      = 16'hE000;
  localparam logic [15:0] OFF_TIMER_CMP  = 16'hE004;
  localparam logic [15:0] OFF_TIMER_CTRL = 16'hE008;

  localparam logic [13:0] W_LED        = OFF_LED[15:2];
  localparam logic [13:0] W_SWITCH     = OFF_SWITCH[15:2];
  localparam logic [13:0] W_NUM        = OFF_NUM[15:2];
  localparam logic [13:0] W_SCRATCH    = OFF_SCRATCH[15:2];
  localparam logic [13:0] W_TIMER      = OFF_TIMER[15:2];
  localparam logic [13:0] W_TIMER_CMP  = OFF_TIMER_CMP[15:2];
  localparam logic [13:0] W_TIMER_CTRL = OFF_TIMER_CTRL[15:2];

  localparam int CTRL_EN   = 0;
  localparam int CTRL_PEND = 1;

  localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

  function automatic logic [31:0] bmerge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  wen
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i+:8] = wen[i] ? new_v[8*i+:8] : old_v[8*i+:8];
    return r;
  endfunction

endpackage

// File: rtl/confreg_timer.sv
// Free-running timer with compare interrupt; built only with CONFREG_TIMER_EN.
`ifdef CONFREG_TIMER_EN
module confreg_timer
  import confreg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_timer_i,
  input  logic        wr_cmp_i,
  input  logic        wr_ctrl_i,
  input  logic [3:0]  wen_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] timer_o,
  output logic [31:0] cmp_o,
  output logic [31:0] ctrl_o,
  output logic        irq_o
);

  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        pend_q, pend_d;

  always_comb begin
    timer_d = timer_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    pend_d  = pend_q;
    if (wr_timer_i)
      timer_d = bmerge(timer_q, wdata_i, wen_i);
    else if (en_q)
      timer_d = timer_q + 32'd1;
    if (wr_cmp_i)
      cmp_d = bmerge(cmp_q, wdata_i, wen_i);
    if (wr_ctrl_i && wen_i[0]) begin
      en_d = wdata_i[CTRL_EN];
      if (wdata_i[CTRL_PEND])
        pend_d = 1'b0;
    end
    // a match on this edge beats a same-cycle clear
    if (en_q && timer_q == cmp_q)
      pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      cmp_q   <= TIMER_CMP_RST;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    ctrl_o            = '0;
    ctrl_o[CTRL_EN]   = en_q;
    ctrl_o[CTRL_PEND] = pend_q;
  end

  assign timer_o = timer_q;
  assign cmp_o   = cmp_q;
  assign irq_o   = pend_q;

endmodule
`endif

// File: rtl/confreg_resp.sv
// Board config register responder on the data SRAM-like port.
// Timer block present only when CONFREG_TIMER_EN is defined.
module confreg_resp
  import confreg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1FAF_0000,
  parameter int          SW_W      = 8,
  parameter int          LED_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_wen,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  input  logic [SW_W-1:0]  switch,
  output logic [LED_W-1:0] led,
  output logic [31:0]      num_data,
  output logic             timer_irq
);

  logic        hit, wr, rd;
  logic [13:0] woff;
  logic        unused_ok;

  assign hit  = data_sram_en &&
                data_sram_addr[31:16] == BASE_ADDR[31:16];
  assign wr   = hit && (data_sram_wen != 4'b0000);
  assign rd   = hit && (data_sram_wen == 4'b0000);
  assign woff = data_sram_addr[15:2];
  assign unused_ok = ^data_sram_addr[1:0];

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      num_q, num_d;
  logic [31:0]      scr_q, scr_d;
  logic [SW_W-1:0]  sw1_q, sw2_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      led_m;

`ifdef CONFREG_TIMER_EN
  logic [31:0] tmr_v, cmp_v, ctrl_v;

  confreg_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .wr_timer_i (wr && woff == W_TIMER),
    .wr_cmp_i   (wr && woff == W_TIMER_CMP),
    .wr_ctrl_i  (wr && woff == W_TIMER_CTRL),
    .wen_i      (data_sram_wen),
    .wdata_i    (data_sram_wdata),
    .timer_o    (tmr_v),
    .cmp_o      (cmp_v),
    .ctrl_o     (ctrl_v),
    .irq_o      (timer_irq)
  );
`else
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    led_d = led_q;
    num_d = num_q;
    scr_d = scr_q;
    led_m = bmerge(32'(led_q), data_sram_wdata, data_sram_wen);
    if (wr) begin
      case (woff)
        W_LED:     led_d = LED_W'(led_m);
        W_NUM:     num_d = bmerge(num_q, data_sram_wdata, data_sram_wen);
        W_SCRATCH: scr_d = bmerge(scr_q, data_sram_wdata, data_sram_wen);
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      case (woff)
        W_LED:        rdata_d = 32'(led_q);
        W_SWITCH:     rdata_d = 32'(sw2_q);
        W_NUM:        rdata_d = num_q;
        W_SCRATCH:    rdata_d = scr_q;
`ifdef CONFREG_TIMER_EN
        W_TIMER:      rdata_d = tmr_v;
        W_TIMER_CMP:  rdata_d = cmp_v;
        W_TIMER_CTRL: rdata_d = ctrl_v;
`endif
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      num_q   <= '0;
      scr_q   <= '0;
      sw1_q   <= '0;
      sw2_q   <= '0;
      rdata_q <= '0;
    end else begin
      led_q   <= led_d;
      num_q   <= num_d;
      scr_q   <= scr_d;
      sw1_q   <= switch;
      sw2_q   <= sw1_q;
      rdata_q <= rdata_d;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign num_data        = num_q;

endmodule
